led_shift_ctrl: RTL and testbench

- Controller that sequences one serial shift frame to an external 74HC595-style LED/segment shift-register chain.
- A frame is triggered by each rising edge of the periodic sync pulse from the board's sync-pulse generator.
- Captures a parallel data word, shifts it out bit-serially with a generated shift clock, then pulses the storage latch.
- Sits between the display data registers and the board pins; the only sequencer of the chain.

---
 rtl/led_shift_ctrl.sv | 159 +++++++++++++++
 tb/tb_led_shift_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_ctrl.sv
// Serial frame sequencer for a 74HC595-style shift-register chain: on each
// sync edge it captures a parallel word, shifts it out with sclk, then pulses latch.
module led_shift_ctrl #(
    parameter int WIDTH       = 16,
    parameter int HALF_PERIOD = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_tick,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             miss,
    output logic             sclk,
    output logic             sdo,
    output logic             latch,
    output logic             clr_n
);

    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT_L = 3'd1,
        SHIFT_H = 3'd2,
        LATCH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    logic             sync_d;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [PW-1:0]    phase;
    logic             start;
    logic             ph_last;
    logic             first_bit;
    logic             next_bit;

    assign start   = sync_tick & ~sync_d;
    assign ph_last = (phase == PH_LAST);

    // Shift toward the output end; the exposed bit is what sdo shows next.
    always_comb begin
        shreg_nxt = '0;
        first_bit = 1'b0;
        next_bit  = 1'b0;
        if (MSB_FIRST) begin
            shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            first_bit = data[WIDTH-1];
            next_bit  = shreg[WIDTH-2];
        end else begin
            shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
            first_bit = data[0];
            next_bit  = shreg[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sync_d  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            phase   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            miss    <= 1'b0;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
            latch   <= 1'b0;
            clr_n   <= 1'b0;
        end else begin
            sync_d <= sync_tick;
            clr_n  <= 1'b1;
            done   <= 1'b0;
            // Any sync edge while a frame is in flight (DONE included) is dropped.
            miss   <= start && (state != IDLE);

            case (state)
                IDLE: begin
                    sclk  <= 1'b0;
                    sdo   <= 1'b0;
                    latch <= 1'b0;
                    busy  <= 1'b0;
                    if (start && enable) begin
                        shreg   <= data;
                        bit_cnt <= '0;
                        phase   <= '0;
                        sdo     <= first_bit;
                        busy    <= 1'b1;
                        state   <= SHIFT_L;
                    end
                end

                SHIFT_L: begin
                    if (ph_last) begin
                        phase <= '0;
                        sclk  <= 1'b1;
                        state <= SHIFT_H;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                SHIFT_H: begin
                    if (ph_last) begin
                        phase <= '0;
                        sclk  <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            sdo   <= 1'b0;
                            latch <= 1'b1;
                            state <= LATCH;
                        end else begin
                            shreg   <= shreg_nxt;
                            bit_cnt <= bit_cnt + 1'b1;
                            sdo     <= next_bit;
                            state   <= SHIFT_L;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                LATCH: begin
                    if (ph_last) begin
                        phase <= '0;
                        latch <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sclk  <= 1'b0;
                    sdo   <= 1'b0;
                    latch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Bench for led_shift_ctrl: default instance and an 8-bit LSB-first, HALF_PERIOD=1
// instance, each checked every cycle against a frame-time model plus literal pins.
module tb_led_shift_ctrl;

    localparam int WA = 16, HA = 2;
    localparam int WB = 8,  HB = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sync_a = 0, en_a = 1, sync_b = 0, en_b = 1;
    logic [15:0]   data_a = 16'hA5C3;
    logic [7:0]    data_b = 8'h01;
    logic busy_a, done_a, miss_a, sclk_a, sdo_a, latch_a, clr_a;
    logic busy_b, done_b, miss_b, sclk_b, sdo_b, latch_b, clr_b;

    led_shift_ctrl #(.WIDTH(WA), .HALF_PERIOD(HA), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .sync_tick(sync_a), .enable(en_a), .data(data_a),
        .busy(busy_a), .done(done_a), .miss(miss_a), .sclk(sclk_a), .sdo(sdo_a),
        .latch(latch_a), .clr_n(clr_a));

    led_shift_ctrl #(.WIDTH(WB), .HALF_PERIOD(HB), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .sync_tick(sync_b), .enable(en_b), .data(data_b),
        .busy(busy_b), .done(done_b), .miss(miss_b), .sclk(sclk_b), .sdo(sdo_b),
        .latch(latch_b), .clr_n(clr_b));

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h @%0t", name, got, exp, $time);
        end
    endtask

    // Model: a frame is just "cycles since the start edge"; every output follows from that.
    logic        m_busy [2] = '{0, 0};
    int          m_t    [2] = '{0, 0};
    logic [15:0] m_data [2] = '{0, 0};
    logic        m_sd   [2] = '{0, 0};
    logic        m_miss [2] = '{0, 0};
    logic        m_clr  [2] = '{0, 0};

    task automatic model_step(input int i, input logic st, input logic en, input logic [15:0] d);
        int w, hp;
        logic start, was;
        w = (i == 0) ? WA : WB;
        hp = (i == 0) ? HA : HB;
        start = st & ~m_sd[i];
        m_sd[i] = st;
        was = m_busy[i];
        m_miss[i] = start && was;
        m_clr[i] = 1'b1;
        if (was) begin
            m_t[i]++;
            if (m_t[i] == 2*hp*w + hp + 1) m_busy[i] = 1'b0;
        end
        if (start && !was && en) begin
            m_busy[i] = 1'b1;
            m_t[i] = 0;
            m_data[i] = d;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_t[i] = 0; m_sd[i] = 0; m_miss[i] = 0; m_clr[i] = 0;
            end
        end else begin
            model_step(0, sync_a, en_a, data_a);
            model_step(1, sync_b, en_b, {8'h00, data_b});
        end
    end

    // {busy, done, miss, sclk, sdo, latch, clr_n}
    function automatic logic [6:0] model_out(input int i);
        int w, hp, t, b;
        logic mf, sc, so, la, dn;
        w = (i == 0) ? WA : WB;
        hp = (i == 0) ? HA : HB;
        mf = (i == 0);
        t = m_t[i];
        sc = 0; so = 0; la = 0; dn = 0;
        if (!m_busy[i]) return {1'b0, 1'b0, m_miss[i], 4'b0000} | {6'b0, m_clr[i]};
        if (t < 2*hp*w) begin
            b = t / (2*hp);
            sc = (t % (2*hp)) >= hp;
            so = mf ? m_data[i][w-1-b] : m_data[i][b];
        end else if (t < 2*hp*w + hp) begin
            la = 1;
        end else begin
            dn = 1;
        end
        return {1'b1, dn, m_miss[i], sc, so, la, m_clr[i]};
    endfunction

    always @(negedge clk) begin
        check("cycle_a", {busy_a, done_a, miss_a, sclk_a, sdo_a, latch_a, clr_a}, model_out(0));
        check("cycle_b", {busy_b, done_b, miss_b, sclk_b, sdo_b, latch_b, clr_b}, model_out(1));
    end

    // Directed frame observer; results left in these variables.
    int          f_rises, f_done_k, f_fall_k, f_misses, f_busy0;
    logic [15:0] f_seq;

    task automatic frame(input int sel, input int hold, input int n,
                         input int chg_k, input int ex1, input int ex2);
        logic prev, sc, so, bz, dn, ms;
        prev = 0; f_rises = 0; f_seq = 0; f_done_k = -1; f_fall_k = -1; f_misses = 0; f_busy0 = 0;
        @(negedge clk);
        if (sel == 0) sync_a = 1; else sync_b = 1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sc = sel == 0 ? sclk_a : sclk_b;
            so = sel == 0 ? sdo_a  : sdo_b;
            bz = sel == 0 ? busy_a : busy_b;
            dn = sel == 0 ? done_a : done_b;
            ms = sel == 0 ? miss_a : miss_b;
            if (k == 0) f_busy0 = int'(bz);
            if (sc && !prev) begin f_rises++; f_seq = {f_seq[14:0], so}; end
            prev = sc;
            if (dn && f_done_k < 0) f_done_k = k;
            if (!bz && f_fall_k < 0) f_fall_k = k;
            if (ms) f_misses++;
            if (k == hold - 1 || k == ex1 + 1 || k == ex2 + 1) begin
                if (sel == 0) sync_a = 0; else sync_b = 0;
            end
            if (k == ex1 || k == ex2) begin
                if (sel == 0) sync_a = 1; else sync_b = 1;
            end
            if (k == chg_k) data_a = 16'h0000;
        end
    endtask

    initial begin
        int flag;
        #1;
        check("reset_a", {busy_a, done_a, miss_a, sclk_a, sdo_a, latch_a, clr_a}, 0);
        check("reset_b", {busy_b, done_b, miss_b, sclk_b, sdo_b, latch_b, clr_b}, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("clr_release", clr_a, 1);

        // Default frame, 1-cycle tick.
        frame(0, 1, 75, -1, -1, -1);
        check("a_rises", f_rises, 16);
        check("a_seq", f_seq, 16'hA5C3);
        check("a_done_k", f_done_k, 66);
        check("a_fall_k", f_fall_k, 67);
        check("a_nomiss", f_misses, 0);

        // 2-cycle tick, data cleared mid-frame, then a second tick 4096 cycles later.
        frame(0, 2, 75, 10, -1, -1);
        check("hold_rises", f_rises, 16);
        check("hold_seq", f_seq, 16'hA5C3);
        check("hold_nomiss", f_misses, 0);
        data_a = 16'hA5C3;
        repeat (4096 - 76) @(negedge clk);
        frame(0, 2, 75, -1, -1, -1);
        check("rep_seq", f_seq, 16'hA5C3);
        check("rep_nomiss", f_misses, 0);

        // Extra sync edges 30 cycles in and during DONE.
        frame(0, 1, 80, -1, 29, 66);
        check("miss_count", f_misses, 2);
        check("miss_seq", f_seq, 16'hA5C3);
        check("miss_rises", f_rises, 16);
        check("miss_fall", f_fall_k, 67);

        // Small LSB-first instance.
        frame(1, 1, 25, -1, -1, -1);
        check("b_rises", f_rises, 8);
        check("b_seq", f_seq, 16'h0080);
        check("b_fall_k", f_fall_k, 18);
        check("b_done_k", f_done_k, 17);

        // Reset during bit 7 (sclk-high phase).
        @(negedge clk); sync_a = 1;
        @(negedge clk); sync_a = 0;
        repeat (30) @(negedge clk);
        check("pre_rst_busy", {busy_a, sclk_a}, 2'b11);
        #2 rst_n = 0;
        #1 check("async_rst", {busy_a, sclk_a, sdo_a, latch_a, clr_a}, 0);
        @(negedge clk); #2 rst_n = 1;
        @(negedge clk);
        check("clr_after_rel", clr_a, 1);
        frame(0, 1, 75, -1, -1, -1);
        check("post_rst_seq", f_seq, 16'hA5C3);
        check("post_rst_rises", f_rises, 16);

        // enable low: edges ignored silently.
        en_a = 0; flag = 0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk); sync_a = 1;
            @(negedge clk); sync_a = 0;
            repeat (8) begin
                @(negedge clk);
                if (busy_a || sclk_a || miss_a) flag = 1;
            end
        end
        check("en_low_quiet", flag, 0);
        en_a = 1;
        frame(0, 1, 75, -1, -1, -1);
        check("en_high_busy0", f_busy0, 1);
        check("en_high_seq", f_seq, 16'hA5C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
